// File: rtl/ram_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : ram_rr_arbiter_if
//  Brief    : Requester and RAM-side signal bundle for the two-port RR arbiter
//  Revision : 1.0  initial release
// ============================================================================
interface ram_rr_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
);
    logic                  m0_valid;
    logic                  m0_we;
    logic [ADDR_WIDTH-1:0] m0_addr;
    logic [DATA_WIDTH-1:0] m0_wdata;
    logic                  m0_ready;
    logic                  m0_rsp_valid;
    logic [DATA_WIDTH-1:0] m0_rsp_data;

    logic                  m1_valid;
    logic                  m1_we;
    logic [ADDR_WIDTH-1:0] m1_addr;
    logic [DATA_WIDTH-1:0] m1_wdata;
    logic                  m1_ready;
    logic                  m1_rsp_valid;
    logic [DATA_WIDTH-1:0] m1_rsp_data;

    logic                  ram_en;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_din;
    logic [DATA_WIDTH-1:0] ram_dout;

    modport slave (
        input  m0_valid, m0_we, m0_addr, m0_wdata,
        input  m1_valid, m1_we, m1_addr, m1_wdata,
        input  ram_dout,
        output m0_ready, m0_rsp_valid, m0_rsp_data,
        output m1_ready, m1_rsp_valid, m1_rsp_data,
        output ram_en, ram_we, ram_addr, ram_din
    );

    modport master (
        output m0_valid, m0_we, m0_addr, m0_wdata,
        output m1_valid, m1_we, m1_addr, m1_wdata,
        output ram_dout,
        input  m0_ready, m0_rsp_valid, m0_rsp_data,
        input  m1_ready, m1_rsp_valid, m1_rsp_data,
        input  ram_en, ram_we, ram_addr, ram_din
    );
endinterface
`default_nettype wire

// File: rtl/ram_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ram_rr_arbiter
//  Brief    : Two-requester round-robin arbiter driving a single-port sync RAM
//  Revision : 1.0  initial release
// ============================================================================
module ram_rr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    ram_rr_arbiter_if.slave      bus
);
    typedef enum logic [0:0] {
        PRI_M0 = 1'b0,
        PRI_M1 = 1'b1
    } pri_t;

    pri_t                  r_pri;
    pri_t                  w_pri_next;
    logic                  w_gnt0;
    logic                  w_gnt1;
    logic                  w_sel_we;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;

    logic                  r_en;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_din;
    logic                  r_rd_iss;
    logic                  r_rd_tag;
    logic                  r_rsp_v;
    logic                  r_rsp_tag;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pri <= PRI_M0;
        end else begin
            r_pri <= w_pri_next;
        end
    end

    // Priority pointer names the port that wins the next tie; it moves only on a grant.
    always_comb begin
        w_gnt0     = 1'b0;
        w_gnt1     = 1'b0;
        w_pri_next = r_pri;
        if (!rst) begin
            if (bus.m0_valid && (!bus.m1_valid || r_pri == PRI_M0)) begin
                w_gnt0 = 1'b1;
            end else if (bus.m1_valid) begin
                w_gnt1 = 1'b1;
            end
        end
        if (w_gnt0) begin
            w_pri_next = PRI_M1;
        end else if (w_gnt1) begin
            w_pri_next = PRI_M0;
        end
    end

    always_comb begin
        w_sel_we    = bus.m0_we;
        w_sel_addr  = bus.m0_addr;
        w_sel_wdata = bus.m0_wdata;
        if (w_gnt1) begin
            w_sel_we    = bus.m1_we;
            w_sel_addr  = bus.m1_addr;
            w_sel_wdata = bus.m1_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_en      <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_din     <= '0;
            r_rd_iss  <= 1'b0;
            r_rd_tag  <= 1'b0;
            r_rsp_v   <= 1'b0;
            r_rsp_tag <= 1'b0;
        end else begin
            r_en      <= w_gnt0 | w_gnt1;
            r_rd_iss  <= (w_gnt0 | w_gnt1) & ~w_sel_we;
            r_rd_tag  <= w_gnt1;
            r_rsp_v   <= r_rd_iss;
            r_rsp_tag <= r_rd_tag;
            if (w_gnt0 | w_gnt1) begin
                r_we   <= w_sel_we;
                r_addr <= w_sel_addr;
                r_din  <= w_sel_we ? w_sel_wdata : '0;
            end else begin
                r_we   <= 1'b0;
            end
        end
    end

    assign bus.m0_ready     = w_gnt0;
    assign bus.m1_ready     = w_gnt1;
    assign bus.ram_en       = r_en;
    assign bus.ram_we       = r_we;
    assign bus.ram_addr     = r_addr;
    assign bus.ram_din      = r_din;
    assign bus.m0_rsp_valid = r_rsp_v & ~r_rsp_tag;
    assign bus.m1_rsp_valid = r_rsp_v & r_rsp_tag;
    assign bus.m0_rsp_data  = bus.ram_dout;
    assign bus.m1_rsp_data  = bus.ram_dout;
endmodule
`default_nettype wire

// File: tb/tb_ram_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram_rr_arbiter
//  Brief    : Self-checking bench for ram_rr_arbiter with RAM and reference model
//  Revision : 1.0  initial release
// ============================================================================
module tb_ram_rr_arbiter;
    localparam int DW = 8;
    localparam int AW = 3;

    logic clk;
    logic rst;

    ram_rr_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    ram_rr_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM with registered read data
    logic [DW-1:0] ram_mem [2**AW];
    always @(posedge clk) begin
        if (bus.ram_en) begin
            if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_din;
            bus.ram_dout <= ram_mem[bus.ram_addr];
        end
    end

    typedef struct {
        int            port;
        int            due;
        logic [DW-1:0] data;
    } rsp_t;

    rsp_t          exp_q[$];
    logic [DW-1:0] ref_mem [2**AW];
    int            ref_last;
    logic          exp_en, exp_we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_din;
    int            cyc;
    int            n_cmp, n_err;

    bit            p_valid [2];
    bit            p_we    [2];
    logic [AW-1:0] p_addr  [2];
    logic [DW-1:0] p_wdata [2];
    int            mode    [2];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic issue(int port, bit we, int addr, int data);
        p_valid[port] = 1'b1;
        p_we[port]    = we;
        p_addr[port]  = AW'(addr);
        p_wdata[port] = DW'(data);
    endtask

    task automatic refill(int i);
        if (mode[i] == 1) begin
            if ($urandom_range(0, 9) < 7) issue(i, 1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 255));
        end else if (mode[i] == 2) begin
            issue(i, 1'b0, $urandom_range(0, 7), 0);
        end
    endtask

    // One clock: drive, check at negedge, then advance the reference model.
    task automatic tick();
        bit [1:0] g;
        bit       r0, r1;
        logic [DW-1:0] rd;
        int       k;
        bus.m0_valid = p_valid[0]; bus.m0_we = p_we[0]; bus.m0_addr = p_addr[0]; bus.m0_wdata = p_wdata[0];
        bus.m1_valid = p_valid[1]; bus.m1_we = p_we[1]; bus.m1_addr = p_addr[1]; bus.m1_wdata = p_wdata[1];
        g = 2'b00;
        if (!rst) begin
            if (p_valid[0] && p_valid[1]) g = (ref_last == 0) ? 2'b10 : 2'b01;
            else g = {p_valid[1], p_valid[0]};
        end
        r0 = 1'b0; r1 = 1'b0; rd = '0;
        if (exp_q.size() != 0) begin
            if (exp_q[0].due == cyc) begin
                r0 = (exp_q[0].port == 0);
                r1 = (exp_q[0].port == 1);
                rd = exp_q[0].data;
            end
        end
        @(negedge clk);
        chk("m0_ready", 32'(bus.m0_ready), 32'(g[0]));
        chk("m1_ready", 32'(bus.m1_ready), 32'(g[1]));
        chk("ram_en", 32'(bus.ram_en), 32'(exp_en));
        chk("ram_we", 32'(bus.ram_we), 32'(exp_we));
        chk("ram_addr", 32'(bus.ram_addr), 32'(exp_addr));
        chk("ram_din", 32'(bus.ram_din), 32'(exp_din));
        chk("m0_rsp_valid", 32'(bus.m0_rsp_valid), 32'(r0));
        chk("m1_rsp_valid", 32'(bus.m1_rsp_valid), 32'(r1));
        if (r0) chk("m0_rsp_data", 32'(bus.m0_rsp_data), 32'(rd));
        if (r1) chk("m1_rsp_data", 32'(bus.m1_rsp_data), 32'(rd));
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            ref_last = 1;
            exp_en = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_din = '0;
        end else begin
            if (r0 || r1) void'(exp_q.pop_front());
            if (g != 2'b00) begin
                k = g[1] ? 1 : 0;
                ref_last = k;
                exp_en   = 1'b1;
                exp_we   = p_we[k];
                exp_addr = p_addr[k];
                exp_din  = p_we[k] ? p_wdata[k] : '0;
                if (p_we[k]) ref_mem[p_addr[k]] = p_wdata[k];
                else exp_q.push_back('{port: k, due: cyc + 2, data: ref_mem[p_addr[k]]});
                p_valid[k] = 1'b0;
            end else begin
                exp_en = 1'b0;
                exp_we = 1'b0;
            end
        end
        for (int i = 0; i < 2; i++) if (!p_valid[i]) refill(i);
        cyc++;
        #1;
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drain(string tag);
        for (int i = 0; i < 60 && (p_valid[0] || p_valid[1] || exp_q.size() != 0); i++) tick();
        chk(tag, 32'(p_valid[0] || p_valid[1] || exp_q.size() != 0), 32'd0);
    endtask

    initial begin
        n_cmp = 0; n_err = 0; cyc = 0;
        ref_last = 1;
        exp_en = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_din = '0;
        for (int i = 0; i < 2**AW; i++) begin
            ram_mem[i] = '0;
            ref_mem[i] = '0;
        end
        for (int i = 0; i < 2; i++) begin
            p_valid[i] = 1'b0; p_we[i] = 1'b0; p_addr[i] = '0; p_wdata[i] = '0; mode[i] = 0;
        end
        rst = 1'b1;
        @(posedge clk); #1;

        // Step 1: reset, m0 write then read of address 3
        ticks(2);
        rst = 1'b0;
        issue(0, 1'b1, 3, 8'hA5);
        tick();
        issue(0, 1'b0, 3, 0);
        drain("t1_drain");
        chk("t1_mem3", 32'(ref_mem[3]), 32'h0000_00A5);

        // Step 2: continuous reads on both ports from reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mode[0] = 2; mode[1] = 2;
        refill(0); refill(1);
        ticks(8);
        mode[0] = 0; mode[1] = 0;
        drain("t2_drain");

        // Step 3: m1 alone for four slots, then a tie
        mode[1] = 2;
        refill(1);
        ticks(4);
        mode[0] = 2;
        refill(0);
        ticks(4);
        mode[0] = 0; mode[1] = 0;
        drain("t3_drain");

        // Step 4: write then immediate read of the same address from the other port
        issue(0, 1'b1, 7, 8'h3C);
        tick();
        issue(1, 1'b0, 7, 0);
        drain("t4_drain");

        // Step 5: reset right after a read accept discards its response
        issue(0, 1'b0, 3, 0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_q_cleared", 32'(exp_q.size()), 32'd0);
        ticks(2);
        issue(0, 1'b0, 2, 0);
        issue(1, 1'b0, 5, 0);
        drain("t5_drain");

        // Step 6: m1 fills memory with idle gaps, m0 reads back through the 7->0 wrap
        for (int i = 0; i < 8; i++) begin
            issue(1, 1'b1, i, i ^ 8'hFF);
            ticks(2);
        end
        for (int i = 0; i < 8; i++) begin
            issue(0, 1'b0, (5 + i) % 8, 0);
            tick();
        end
        drain("t6_drain");
        for (int i = 0; i < 8; i++) chk("t6_ref_mem", 32'(ref_mem[i]), 32'(i ^ 8'hFF));

        // Randomized mixed traffic with reference-model checking
        mode[0] = 1; mode[1] = 1;
        ticks(400);
        mode[0] = 0; mode[1] = 0;
        drain("rand_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
